uart_rx: RTL
============

# uart_rx

UART receiver paired with the transmit path. Recovers serial frames from `RX_IN` by oversampling: an idle-high line, one start bit (0), 2**DATAWIDTH data bits LSB first, an optional parity bit and one stop bit (1). Outputs the parallel word with a one-cycle valid strobe, and flags parity and framing errors.

## Interface
Parameters:
- `DATAWIDTH`, default 3: data word width is 2**DATAWIDTH bits.
- `PRESCALE`, default 8: CLK cycles per bit; even, ≥ 4.

Ports:
- `CLK` in 1: single clock, PRESCALE × bit rate.
- `RST_ASYN` in 1: reset, asynchronous, active-high.
- `RX_IN` in 1: serial line, asynchronous to CLK.
- `PAR_EN` in 1: 1 = frame carries a parity bit.
- `PAR_TYP` in 1: 0 = even, 1 = odd.
- `P_DATA` out 2**DATAWIDTH: last good word, held until the next good frame.
- `Data_Valid` out 1: one-cycle pulse, `P_DATA` updated in the same cycle.
- `PAR_ERR` out 1: one-cycle pulse, parity mismatch.
- `STP_ERR` out 1: one-cycle pulse, stop bit sampled 0.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- `RX_IN` passes through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized `rx_s`.
- Edge counter `edge_cnt` (0..PRESCALE-1) and bit counter `bit_cnt` (0..2**DATAWIDTH-1). Half point h = PRESCALE/2.
- Decision cycle for each bit is `edge_cnt == h+1`.
- States: IDLE → START → DATA → PARITY → STOP → IDLE.
  - **IDLE**: `rx_s == 0` → START with `edge_cnt = 0`. `PAR_EN` and `PAR_TYP` are latched in this cycle and held for the whole frame.
  - **START**: at the decision cycle, if the sampled bit is 1 it is a glitch → IDLE, no outputs pulse. Otherwise the state continues to `edge_cnt == PRESCALE-1`, then goes to DATA.
  - **DATA**: each decision shifts the sampled bit into `shift[bit_cnt]` (LSB first). At `edge_cnt == PRESCALE-1` with the last bit received, go to PARITY if parity is latched enabled, else STOP.
  - **PARITY**: the bit is sampled and compared to the expected parity: XOR of the data, inverted for odd. The mismatch is stored. At `edge_cnt == PRESCALE-1` → STOP.
  - **STOP**: at the decision cycle, transition → IDLE immediately (mid stop bit) so a back-to-back start edge is caught. Outputs are registered on that transition:
    - stop = 0 → `STP_ERR`.
    - stop = 1 with a parity mismatch → `PAR_ERR`.
    - otherwise `P_DATA <= shift` and `Data_Valid`.
    - If both errors occur, both pulse. `Data_Valid` never pulses with an error.
- `edge_cnt` wraps to 0 at PRESCALE-1 on every bit.

## Timing
- Reset values: state IDLE, counters 0, `P_DATA` 0, `Data_Valid` 0, `PAR_ERR` 0, `STP_ERR` 0, `busy` 0. Reset mid-frame aborts the frame with no pulses.
- Let T0 be the cycle `RX_IN` first goes low. `rx_s` goes low at T0+2, which is START with `edge_cnt = 0`.
- Output pulse cycle: T0+2 + PRESCALE·(1+N+P) + h+2, where N = 2**DATAWIDTH and P = latched parity enable. The +2 covers the decision cycle plus the registered output.
- Example, PRESCALE 8, N 8, no parity: pulse at T0+2+72+6 = T0+80.
- `busy` rises at T0+3 and falls in the pulse cycle.
- `PAR_EN`/`PAR_TYP` changes during a frame have no effect until the next IDLE→START.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined: each bit value is the 2-of-3 majority of `rx_s` at `edge_cnt` h-1, h, h+1.
- Not defined: each bit value is `rx_s` at `edge_cnt == h`.
- Decision-cycle timing is identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - parity type constants (EVEN = 0, ODD = 1);
  - `PRESCALE_MIN = 4`.
- Sub-module `uart_rx_sampler`: owns `edge_cnt` and the sample registers/vote. Outputs `sampled_bit`, `decide` (`edge_cnt == h+1`) and `bit_end` (`edge_cnt == PRESCALE-1`). The FSM, shift register and error logic live in `uart_rx`.

## Test plan
- PRESCALE 8, `PAR_EN` 0, frame 0xA5 → `Data_Valid` at T0+80, `P_DATA` = 0xA5, no error pulses.
- `PAR_EN` 1, `PAR_TYP` 0, 0xA5 with parity bit 0 → valid with 0xA5. Same frame with parity bit 1 → `PAR_ERR` pulse, `P_DATA` keeps its previous value, no `Data_Valid`.
- 0x3C with stop bit 0 → `STP_ERR` only; a following good 0xC3 frame, started 1 bit-time later → valid 0xC3.
- `RX_IN` low for 2 cycles then high → `busy` pulses, returns to IDLE, no output pulses.
- Back-to-back frames 0x3C, 0xC3, each started right after the previous stop bit → two `Data_Valid` pulses 80 cycles apart, values in order.
- `RST_ASYN` asserted at mid-data of 0xFF → all outputs 0 immediately; the next frame 0x81 is received correctly.
- With the vote enabled, a 1-cycle glitch at `edge_cnt == h` on a data bit → bit received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, parity types, limits.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  localparam int PRESCALE_MIN = 4;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and mid-bit sampling for the UART receiver.
// UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_s_i,
  input  logic run_i,
  output logic sampled_bit,
  output logic decide,
  output logic bit_end
);

  localparam int PS = (PRESCALE < PRESCALE_MIN) ? PRESCALE_MIN : PRESCALE;
  localparam int H  = PS / 2;
  localparam int CW = $clog2(PS);

  localparam logic [CW-1:0] LAST  = CW'(PS - 1);
  localparam logic [CW-1:0] MID   = CW'(H);
  localparam logic [CW-1:0] DEC   = CW'(H + 1);

  logic [CW-1:0] edge_cnt_q, edge_cnt_d;

  always_comb begin
    edge_cnt_d = '0;
    if (run_i && edge_cnt_q != LAST)
      edge_cnt_d = edge_cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) edge_cnt_q <= '0;
    else       edge_cnt_q <= edge_cnt_d;
  end

  assign decide  = (edge_cnt_q == DEC);
  assign bit_end = (edge_cnt_q == LAST);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] PRE = CW'(H - 1);

  logic s_pre_q, s_mid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_pre_q <= 1'b1;
      s_mid_q <= 1'b1;
    end else begin
      if (edge_cnt_q == PRE) s_pre_q <= rx_s_i;
      if (edge_cnt_q == MID) s_mid_q <= rx_s_i;
    end
  end

  // Third vote is the live line value in the decision cycle itself.
  assign sampled_bit = maj3(s_pre_q, s_mid_q, rx_s_i);
`else
  logic s_mid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  s_mid_q <= 1'b1;
    else if (edge_cnt_q == MID) s_mid_q <= rx_s_i;
  end

  assign sampled_bit = s_mid_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, 2**DATAWIDTH data bits, opt parity, stop.
// Build with UART_RX_MAJORITY_VOTE_EN for majority-voted bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATAWIDTH = 3,
  parameter int PRESCALE  = 8
) (
  input  logic                    CLK,
  input  logic                    RST_ASYN,
  input  logic                    RX_IN,
  input  logic                    PAR_EN,
  input  logic                    PAR_TYP,
  output logic [2**DATAWIDTH-1:0] P_DATA,
  output logic                    Data_Valid,
  output logic                    PAR_ERR,
  output logic                    STP_ERR,
  output logic                    busy
);

  localparam int N = 2**DATAWIDTH;
  localparam logic [DATAWIDTH-1:0] LAST_BIT = DATAWIDTH'(N - 1);

  rx_state_e state_q, state_d;

  logic rx_meta_q, rx_s_q;
  logic [DATAWIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [N-1:0] shift_q, shift_d;
  logic [N-1:0] p_data_q, p_data_d;
  logic par_en_q, par_en_d;
  logic par_typ_q, par_typ_d;
  logic par_bad_q, par_bad_d;
  logic dv_q, dv_d;
  logic perr_q, perr_d;
  logic serr_q, serr_d;

  logic run, sampled_bit, decide, bit_end;

  always_ff @(posedge CLK or posedge RST_ASYN) begin
    if (RST_ASYN) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign run = (state_d != IDLE);

  uart_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .clk_i      (CLK),
    .rst_i      (RST_ASYN),
    .rx_s_i     (rx_s_q),
    .run_i      (run),
    .sampled_bit(sampled_bit),
    .decide     (decide),
    .bit_end    (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    p_data_d  = p_data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bad_d = par_bad_q;
    dv_d      = 1'b0;
    perr_d    = 1'b0;
    serr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d   = START;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
        end
      end
      START: begin
        if (decide && sampled_bit) state_d = IDLE;
        else if (bit_end)          state_d = DATA;
      end
      DATA: begin
        if (decide) shift_d[bit_cnt_q] = sampled_bit;
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + DATAWIDTH'(1);
          end
        end
      end
      PARITY: begin
        if (decide)
          par_bad_d = sampled_bit ^ (^shift_q) ^ (par_typ_q == ODD);
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Leave mid stop bit so a back-to-back start edge is not missed.
        if (decide) begin
          state_d = IDLE;
          serr_d  = !sampled_bit;
          perr_d  = par_bad_q;
          if (sampled_bit && !par_bad_q) begin
            p_data_d = shift_q;
            dv_d     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST_ASYN) begin
    if (RST_ASYN) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      p_data_q  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= EVEN;
      par_bad_q <= 1'b0;
      dv_q      <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      p_data_q  <= p_data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bad_q <= par_bad_d;
      dv_q      <= dv_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = dv_q;
  assign PAR_ERR    = perr_q;
  assign STP_ERR    = serr_q;
  assign busy       = (state_q != IDLE);

endmodule
